tqvp_display_scanner: RTL and testbench

TQVP_DISPLAY_SCANNER -- requirements
Module: tqvp_display_scanner

---
 rtl/tqvp_display_scanner.sv | 220 ++++++++++++++++++++++
 tb/tb_tqvp_display_scanner.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_display_scanner.sv
// Scans four 7-segment digits through two daisy-chained 74HC595s: one 16-bit
// frame per digit, shifted MSB first, latched, then held for a dwell time.
//   state    | meaning
//   IDLE     | scanning disabled, all lines low
//   LOAD     | snapshot registers, build frame for current digit
//   SHIFT_LO | SER driven, SRCLK low
//   SHIFT_HI | SER held, SRCLK high
//   LATCH    | RCLK high, transfers shifted frame to outputs
//   HOLD     | dwell on current digit
module tqvp_display_scanner (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_LATCH    = 3'd4,
        S_HOLD     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  dig10_q, dig10_d;
    logic [7:0]  dig32_q, dig32_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] frame_q, frame_d;

    logic [3:0]  nib;
    logic        blank;
    logic [3:0]  dp_bits;
    logic [7:0]  seg_byte;
    logic [3:0]  en_bits;
    logic [15:0] frame_new;
    logic        ser, srclk, rclk;

    logic unused_ui;
    assign unused_ui = ^ui_in;

    function automatic logic [6:0] seg_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dig10_q  <= 8'h00;
            dig32_q  <= 8'h00;
            ctrl_q   <= 8'h00;
            div_q    <= 8'h00;
            dwell_q  <= 8'h00;
            idx_q    <= 2'd0;
            bitcnt_q <= 4'd0;
            timer_q  <= 16'd0;
            frame_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            dig10_q  <= dig10_d;
            dig32_q  <= dig32_d;
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            dwell_q  <= dwell_d;
            idx_q    <= idx_d;
            bitcnt_q <= bitcnt_d;
            timer_q  <= timer_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dig10_d  = dig10_q;
        dig32_d  = dig32_q;
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        dwell_d  = dwell_q;
        idx_d    = idx_q;
        bitcnt_d = bitcnt_q;
        timer_d  = timer_q;
        frame_d  = frame_q;

        if (data_write) begin
            case (address)
                4'h0:    dig10_d = data_in;
                4'h1:    dig32_d = data_in;
                4'h2:    ctrl_d  = data_in;
                4'h3:    div_d   = data_in;
                4'h4:    dwell_d = data_in;
                default: ;
            endcase
        end

        // Leading-zero blanking: a digit blanks only if it and every higher digit are zero.
        case (idx_q)
            2'd0: begin nib = dig10_q[3:0]; blank = 1'b0; end
            2'd1: begin nib = dig10_q[7:4]; blank = (dig10_q[7:4] == 4'h0) && (dig32_q == 8'h00); end
            2'd2: begin nib = dig32_q[3:0]; blank = (dig32_q == 8'h00); end
            default: begin nib = dig32_q[7:4]; blank = (dig32_q[7:4] == 4'h0); end
        endcase
        blank     = blank && ctrl_q[6];
        dp_bits   = ctrl_q[3:0];
        seg_byte  = {dp_bits[idx_q], (blank ? 7'h00 : seg_font(nib))} ^ {8{ctrl_q[5]}};
        en_bits   = (4'b0001 << idx_q) ^ {4{ctrl_q[4]}};
        frame_new = {en_bits, 4'b0000, seg_byte};

        case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                frame_d  = frame_new;
                bitcnt_d = 4'd15;
                timer_d  = {8'h00, div_q};
                state_d  = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (timer_q == 16'd0) begin
                    timer_d = {8'h00, div_q};
                    state_d = S_SHIFT_HI;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_SHIFT_HI: begin
                if (timer_q == 16'd0) begin
                    timer_d = {8'h00, div_q};
                    if (bitcnt_q == 4'd0) begin
                        state_d = S_LATCH;
                    end else begin
                        bitcnt_d = bitcnt_q - 4'd1;
                        state_d  = S_SHIFT_LO;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_LATCH: begin
                if (timer_q == 16'd0) begin
                    timer_d = {dwell_q, 8'hFF};
                    state_d = S_HOLD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_HOLD: begin
                if (timer_q == 16'd0) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_LOAD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!ctrl_q[7]) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        ser   = 1'b0;
        srclk = 1'b0;
        rclk  = 1'b0;
        case (state_q)
            S_SHIFT_LO: ser = frame_q[bitcnt_q];
            S_SHIFT_HI: begin
                ser   = frame_q[bitcnt_q];
                srclk = 1'b1;
            end
            S_LATCH:    rclk = 1'b1;
            default:    ;
        endcase
        uo_out = {4'b0000, rclk, srclk, ser, 1'b0};
    end

    always_comb begin
        case (address)
            4'h0:    data_out = dig10_q;
            4'h1:    data_out = dig32_q;
            4'h2:    data_out = ctrl_q;
            4'h3:    data_out = div_q;
            4'h4:    data_out = dwell_q;
            4'h5:    data_out = {(state_q != S_IDLE), state_q, 2'b00, idx_q};
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_display_scanner.sv
// Directed bench for tqvp_display_scanner: frame vectors from a table plus
// hand-written timing, no-tearing and abort sequences.
module tb_tqvp_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]  dig10;
        logic [7:0]  dig32;
        logic [7:0]  ctrl;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic [15:0] exp2;
        logic [15:0] exp3;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tqvp_display_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        data_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(name, data_out, exp);
    endtask

    task automatic config_regs(input logic [7:0] d10, input logic [7:0] d32, input logic [7:0] dv,
                               input logic [7:0] dw, input logic [7:0] c);
        write_reg(4'h0, d10);
        write_reg(4'h1, d32);
        write_reg(4'h3, dv);
        write_reg(4'h4, dw);
        write_reg(4'h2, c);
    endtask

    // Shift in SER on each SRCLK rise until 16 bits and RCLK seen; optionally
    // pulse a register write right after rise number wr_bit.
    task automatic capture(input int wr_bit, input logic [3:0] wa, input logic [7:0] wd,
                           output logic [15:0] f, output bit ok);
        int   rises = 0;
        logic prev;
        bit   wr_pending = 1'b0;
        f = 16'h0000;
        ok = 1'b0;
        prev = uo_out[2];
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (wr_pending) begin
                data_write = 1'b0;
                wr_pending = 1'b0;
            end
            if (uo_out[2] && !prev) begin
                f = {f[14:0], uo_out[1]};
                rises++;
                if (rises == wr_bit) begin
                    address = wa;
                    data_in = wd;
                    data_write = 1'b1;
                    wr_pending = 1'b1;
                end
            end
            prev = uo_out[2];
            if (rises == 16 && uo_out[3]) begin
                ok = 1'b1;
                break;
            end
        end
        if (wr_pending) data_write = 1'b0;
    endtask

    task automatic expect_frame(input string name, input int wr_bit, input logic [3:0] wa,
                                input logic [7:0] wd, input logic [15:0] exp);
        logic [15:0] f;
        bit          ok;
        capture(wr_bit, wa, wd, f, ok);
        check({name, " done"}, ok, 1);
        check(name, f, exp);
    endtask

    task automatic wait_rises(input int n, output bit ok);
        int   rises = 0;
        logic prev;
        ok = 1'b0;
        prev = uo_out[2];
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (uo_out[2] && !prev) rises++;
            prev = uo_out[2];
            if (rises == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // From the next LOAD: offset to RCLK, offset to the following LOAD, first
    // SRCLK high run, low run between first and second rise, idx at next LOAD.
    task automatic measure(output int t_rclk, output int t_per, output int hi_len,
                           output int lo_len, output logic [1:0] idx_next, output bit ok);
        int   t0;
        int   rises = 0;
        logic prev = 1'b0;
        bit   got_rclk = 1'b0;
        bit   got_load = 1'b0;
        t_rclk = -1;
        t_per = -1;
        hi_len = 0;
        lo_len = 0;
        idx_next = 2'd0;
        ok = 1'b0;
        address = 4'h5;
        t0 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_out[6:4] == 3'd1) begin
                got_load = 1'b1;
                t0 = cyc;
                break;
            end
        end
        if (got_load) begin
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (data_out[6:4] == 3'd1 && got_rclk) begin
                    t_per = cyc - t0;
                    idx_next = data_out[1:0];
                    ok = 1'b1;
                    break;
                end
                if (uo_out[3] && !got_rclk) begin
                    t_rclk = cyc - t0;
                    got_rclk = 1'b1;
                end
                if (uo_out[2] && !prev) rises++;
                if (rises == 1 && uo_out[2]) hi_len++;
                if (rises == 1 && !uo_out[2]) lo_len++;
                prev = uo_out[2];
            end
        end
    endtask

    initial begin
        int          t_rclk, t_per, hi_len, lo_len;
        logic [1:0]  idx_next;
        bit          ok;

        //            dig10  dig32  ctrl   idx0      idx1      idx2      idx3
        vecs[0] = '{8'h21, 8'h43, 8'h80, 16'h1006, 16'h205B, 16'h404F, 16'h8066};
        vecs[1] = '{8'h50, 8'h00, 8'hC0, 16'h103F, 16'h206D, 16'h4000, 16'h8000};
        vecs[2] = '{8'h08, 8'h00, 8'hB1, 16'hE000, 16'hD0C0, 16'hB0C0, 16'h70C0};
        vecs[3] = '{8'hBA, 8'hDC, 8'h8A, 16'h1077, 16'h20FC, 16'h4039, 16'h80DE};
        vecs[4] = '{8'h0E, 8'h30, 8'hC4, 16'h1079, 16'h203F, 16'h40BF, 16'h804F};
        vecs[5] = '{8'h00, 8'h00, 8'hF8, 16'hE0C0, 16'hD0FF, 16'hB0FF, 16'h707F};
        vecs[6] = '{8'h96, 8'hF7, 8'h80, 16'h107D, 16'h206F, 16'h4007, 16'h8071};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset uo_out", uo_out, 8'h00);
        for (int a = 0; a < 6; a++) read_check($sformatf("reset reg %0d", a), 4'(a), 8'h00);

        // Register file readback and unmapped addresses
        write_reg(4'h0, 8'h5A);
        write_reg(4'h3, 8'hC3);
        write_reg(4'h4, 8'h7E);
        write_reg(4'hA, 8'hFF);
        read_check("rb DIG10", 4'h0, 8'h5A);
        read_check("rb DIV", 4'h3, 8'hC3);
        read_check("rb DWELL", 4'h4, 8'h7E);
        read_check("rb addr A", 4'hA, 8'h00);
        read_check("rb STATUS idle", 4'h5, 8'h00);
        check("idle uo_out", uo_out, 8'h00);

        // Reset wins over a simultaneous write
        @(negedge clk);
        rst_n = 1'b0;
        address = 4'h0;
        data_in = 8'h77;
        data_write = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        data_write = 1'b0;
        read_check("rst over write", 4'h0, 8'h00);

        // Frame vectors
        for (int v = 0; v < 7; v++) begin
            do_reset();
            config_regs(vecs[v].dig10, vecs[v].dig32, 8'h00, 8'h00, vecs[v].ctrl);
            expect_frame($sformatf("vec%0d idx0", v), -1, 4'h0, 8'h00, vecs[v].exp0);
            expect_frame($sformatf("vec%0d idx1", v), -1, 4'h0, 8'h00, vecs[v].exp1);
            expect_frame($sformatf("vec%0d idx2", v), -1, 4'h0, 8'h00, vecs[v].exp2);
            expect_frame($sformatf("vec%0d idx3", v), -1, 4'h0, 8'h00, vecs[v].exp3);
        end

        // Timing at DIV=0, DWELL=0: RCLK in the 34th cycle counting LOAD as the first
        do_reset();
        config_regs(8'h21, 8'h43, 8'h00, 8'h00, 8'h80);
        measure(t_rclk, t_per, hi_len, lo_len, idx_next, ok);
        check("t0 done", ok, 1);
        check("t0 rclk offset", t_rclk, 33);
        check("t0 period", t_per, 290);
        check("t0 srclk high", hi_len, 1);
        check("t0 srclk low", lo_len, 1);
        check("t0 next idx", idx_next, 2'd1);

        // Timing at DIV=3, DWELL=1
        do_reset();
        config_regs(8'h00, 8'h00, 8'h03, 8'h01, 8'h80);
        measure(t_rclk, t_per, hi_len, lo_len, idx_next, ok);
        check("t1 done", ok, 1);
        check("t1 rclk offset", t_rclk, 129);
        check("t1 period", t_per, 645);
        check("t1 srclk high", hi_len, 4);
        check("t1 srclk low", lo_len, 4);
        check("t1 next idx", idx_next, 2'd1);
        expect_frame("t1 idx1 frame", -1, 4'h0, 8'h00, 16'h203F);

        // Mid-shift write does not tear the frame; write during LOAD is not captured
        do_reset();
        config_regs(8'h21, 8'h43, 8'h00, 8'h00, 8'h80);
        expect_frame("tear idx0", 3, 4'h0, 8'h07, 16'h1006);
        expect_frame("tear idx1", -1, 4'h0, 8'h00, 16'h203F);
        repeat (257) @(negedge clk);
        read_check("status at LOAD", 4'h5, 8'h92);
        address = 4'h1;
        data_in = 8'h00;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
        expect_frame("load race idx2", -1, 4'h0, 8'h00, 16'h404F);
        expect_frame("tear idx3", -1, 4'h0, 8'h00, 16'h803F);
        expect_frame("tear idx0 new", -1, 4'h0, 8'h00, 16'h1007);

        // Clearing EN mid-shift aborts to IDLE keeping idx
        do_reset();
        config_regs(8'h21, 8'h43, 8'h00, 8'h00, 8'h80);
        expect_frame("abort idx0", -1, 4'h0, 8'h00, 16'h1006);
        wait_rises(5, ok);
        check("abort rises", ok, 1);
        write_reg(4'h2, 8'h00);
        @(negedge clk);
        check("en clear uo_out", uo_out, 8'h00);
        read_check("en clear status", 4'h5, 8'h01);
        write_reg(4'h2, 8'h80);
        expect_frame("resume idx1", -1, 4'h0, 8'h00, 16'h205B);

        // Reset mid-shift
        wait_rises(5, ok);
        check("rst rises", ok, 1);
        address = 4'h5;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst mid uo_out", uo_out, 8'h00);
        read_check("rst mid status", 4'h5, 8'h00);
        read_check("rst mid CTRL", 4'h2, 8'h00);
        read_check("rst mid DIG10", 4'h0, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
